// File: rtl/decompressor_top.sv
// LZRW1-style streaming decompressor: expands literal/copy items into a byte
// stream, one byte per clock, while recording every emitted byte in a circular history.
module decompressor_top #(
  parameter int HISTORY_SIZE = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        control_word_in,
  input  logic        data_in_valid,
  output logic [7:0]  decompressed_byte,
  output logic        out_valid,
  output logic        decompressor_busy
);

  localparam int AW = (HISTORY_SIZE > 1) ? $clog2(HISTORY_SIZE) : 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   wp, rd_ptr;
  logic [AW-1:0]   offset, src_addr;
  logic [4:0]      remaining;
  logic [7:0]      history [HISTORY_SIZE];
  logic            accept, emit;
  logic [7:0]      emit_byte;

  // Truncating the offset to the address width gives the modulo-HISTORY_SIZE wrap.
  assign offset = data_in[AW-1:0];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (data_in_valid)    state_next = EMIT;
      EMIT: if (remaining == 5'd0) state_next = IDLE;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a latch.
  always_comb begin
    accept    = 1'b0;
    emit      = 1'b0;
    src_addr  = rd_ptr;
    emit_byte = history[rd_ptr];
    unique case (state)
      IDLE: begin
        if (data_in_valid) begin
          accept    = 1'b1;
          emit      = 1'b1;
          src_addr  = wp - offset;
          emit_byte = control_word_in ? history[wp - offset] : data_in[7:0];
        end
      end
      EMIT: emit = (remaining != 5'd0);
    endcase
  end

  // Bytes written on one edge are readable on the next, so overlapping copies
  // (offset < length) naturally replay the pattern they are producing.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp                <= '0;
      rd_ptr            <= '0;
      remaining         <= '0;
      out_valid         <= 1'b0;
      decompressed_byte <= 8'h00;
      decompressor_busy <= 1'b0;
    end else begin
      out_valid         <= emit;
      decompressor_busy <= (state_next == EMIT);
      if (emit) begin
        decompressed_byte <= emit_byte;
        wp                <= wp + 1'b1;
        rd_ptr            <= src_addr + 1'b1;
      end
      if (accept)
        remaining <= control_word_in ? 5'(data_in[15:12]) + 5'd2 : 5'd0;
      else if (emit)
        remaining <= remaining - 5'd1;
    end
  end

  // NOTE: the history has to read back as zeros after reset, so it is built from
  // resettable flops rather than an inferred RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < HISTORY_SIZE; i++) history[i] <= 8'h00;
    end else if (emit) begin
      history[wp] <= emit_byte;
    end
  end

endmodule

// File: tb/tb_decompressor_top.sv
// Scoreboard bench for decompressor_top: stimulus pushes expected bytes, a
// negedge monitor pops and compares whenever out_valid is high.
module tb_decompressor_top;

  localparam int HS = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        control_word_in;
  logic        data_in_valid;
  logic [7:0]  decompressed_byte;
  logic        out_valid;
  logic        decompressor_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n_pushed  = 0;
  int n_seen    = 0;
  logic [7:0] exp_q [$];
  logic [7:0] model [$];

  decompressor_top #(.HISTORY_SIZE(HS)) dut (
    .clock             (clock),
    .reset             (reset),
    .data_in           (data_in),
    .control_word_in   (control_word_in),
    .data_in_valid     (data_in_valid),
    .decompressed_byte (decompressed_byte),
    .out_valid         (out_valid),
    .decompressor_busy (decompressor_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Byte-stream model: history starts as HS zeros, every expected byte is appended.
  task automatic model_clear();
    model.delete();
    for (int i = 0; i < HS; i++) model.push_back(8'h00);
  endtask

  task automatic push(input logic [7:0] b);
    exp_q.push_back(b);
    model.push_back(b);
    n_pushed++;
  endtask

  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      n_seen++;
      if (exp_q.size() == 0) check("extra_byte", {24'h0, decompressed_byte}, 32'hFFFF_FFFF);
      else check("byte", {24'h0, decompressed_byte}, {24'h0, exp_q.pop_front()});
    end
  end

  // Holds the item until busy falls; with wiggle set, data_in changes while busy.
  task automatic send(input logic [15:0] d, input logic c, input int len, input bit wiggle);
    int busy_cyc = 0;
    int ov_cyc   = 0;
    int guard    = 0;
    @(negedge clock);
    check("idle_before_accept", {31'h0, decompressor_busy}, 32'd0);
    data_in = d; control_word_in = c; data_in_valid = 1'b1;
    @(negedge clock);
    check("first_byte_latency", {31'h0, out_valid}, 32'd1);
    while (decompressor_busy === 1'b1 && guard < 40) begin
      busy_cyc++;
      if (out_valid === 1'b1) ov_cyc++;
      if (wiggle) begin
        data_in         = 16'h5A00 | 16'(guard);
        control_word_in = ~c;
      end
      @(negedge clock);
      guard++;
    end
    data_in_valid = 1'b0;
    data_in = d; control_word_in = c;
    check("busy_cycles", busy_cyc, len);
    check("valid_cycles", ov_cyc, len);
    check("valid_low_after_item", {31'h0, out_valid}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; data_in = '0; control_word_in = 1'b0; data_in_valid = 1'b0;
    model_clear();

    repeat (3) begin
      @(negedge clock);
      check("rst_busy", {31'h0, decompressor_busy}, 32'd0);
      check("rst_valid", {31'h0, out_valid}, 32'd0);
      check("rst_byte", {24'h0, decompressed_byte}, 32'd0);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("idle_no_valid", {31'h0, out_valid}, 32'd0);
    end

    // Literals then a non-overlapping copy (offset 3, L 3)
    push(8'h41); send(16'h0041, 1'b0, 1, 1'b0);
    push(8'h42); send(16'h0042, 1'b0, 1, 1'b0);
    push(8'h43); send(16'h0043, 1'b0, 1, 1'b0);
    push(8'h41); push(8'h42); push(8'h43);
    send(16'h0003, 1'b1, 3, 1'b0);

    // Overlapping maximum-length copy: offset 1, L 18
    push(8'h78); send(16'h0078, 1'b0, 1, 1'b0);
    repeat (18) push(8'h78);
    send(16'hF001, 1'b1, 18, 1'b0);

    // Inputs changing while busy must be ignored
    push(8'h51); send(16'hAB51, 1'b0, 1, 1'b1);
    push(8'h52); send(16'h0052, 1'b0, 1, 1'b0);
    push(8'h51); push(8'h52); push(8'h51); push(8'h52);
    send(16'h1002, 1'b1, 4, 1'b1);

    // Reset in the middle of an 18-byte copy: only 4 bytes escape
    push(8'h7A); send(16'h007A, 1'b0, 1, 1'b0);
    repeat (4) push(8'h7A);
    @(negedge clock);
    data_in = 16'hF001; control_word_in = 1'b1; data_in_valid = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b1; data_in_valid = 1'b0;
    @(negedge clock);
    check("midcopy_rst_valid", {31'h0, out_valid}, 32'd0);
    check("midcopy_rst_busy", {31'h0, decompressor_busy}, 32'd0);
    check("midcopy_rst_byte", {24'h0, decompressed_byte}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_valid", {31'h0, out_valid}, 32'd0);
    check("midcopy_bytes_drained", exp_q.size(), 0);
    model_clear();

    // History was cleared: a copy from it returns zeros
    push(8'h00); push(8'h00); push(8'h00);
    send(16'h0005, 1'b1, 3, 1'b0);

    // Wrap-around: more than HS bytes, then offset 256 (== HS) reaches back a full window
    for (int i = 0; i < 260; i++) begin
      push(8'(i * 37 + 11));
      send({8'h00, 8'(i * 37 + 11)}, 1'b0, 1, 1'b0);
    end
    for (int k = 0; k < 3; k++) push(model[model.size() - HS]);
    send(16'h0100, 1'b1, 3, 1'b0);

    repeat (5) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    check("byte_total", n_seen, n_pushed);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/decompressor_top.md
# decompressor_top

LZRW1-style streaming decompressor core. It accepts one 16-bit compressed item per handshake, tagged by a control bit as either a literal byte or a back-reference copy. It emits the reconstructed byte stream one byte per clock while keeping a circular history of the bytes it has emitted. It is the top of the decompressor datapath and sits between the compressed-item source and the byte sink.

## Interface
- HISTORY_SIZE, 4096: history window depth in bytes; must be a power of two, 2..4096.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  16  compressed item.
- control_word_in  in  1  item type: 0 = literal, 1 = copy.
- data_in_valid  in  1  the item on data_in/control_word_in is valid.
- decompressed_byte  out  8  output byte; registered.
- out_valid  out  1  decompressed_byte is valid this cycle; registered.
- decompressor_busy  out  1  core is expanding an item and ignores all inputs; registered.

## Operation
- State: history RAM of HISTORY_SIZE bytes, write pointer wp (log2(HISTORY_SIZE) bits), remaining-count, copy read pointer, IDLE/EMIT state machine.
- **IDLE:**
  - busy=0.
  - On a rising edge with data_in_valid=1, the item is accepted and the core enters EMIT.
- **Literal item** (control_word_in=0):
  - length L=1.
  - The byte is data_in[7:0]; data_in[15:8] is ignored.
- **Copy item** (control_word_in=1):
  - offset = data_in[11:0].
  - L = data_in[15:12] + 3, so 3..18.
  - Source byte for output k (k = 0..L-1) is history[(wp_at_accept − offset + k) mod HISTORY_SIZE].
  - Overlap with bytes emitted by the same copy (offset < L) must reproduce the repeating pattern. Example: offset 1, L 5 repeats the last byte 5 times.
- **Every emitted byte** is written to history[wp] and wp increments, wrapping modulo HISTORY_SIZE.
- **EMIT:**
  - One byte per cycle.
  - Returns to IDLE after byte L has been presented.
- **Inputs while busy:** data_in_valid is ignored. The item is not queued.
- **Offsets:**
  - All offset arithmetic is modulo HISTORY_SIZE.
  - Offset 0, or offset > HISTORY_SIZE, reads the wrapped address. No error is flagged.
  - An encoder never produces these offsets.
- **Reset:**
  - Returns the core to IDLE and clears wp to 0.
  - Drives busy=0, out_valid=0 and decompressed_byte=8'h00.
  - Clears history contents to 0.
  - Applies even mid-item; the in-progress item is discarded.

## Timing
- Accept edge E0 (busy=0, data_in_valid=1).
- After edges E0..E(L-1):
  - out_valid=1, busy=1.
  - decompressed_byte holds output byte k after edge Ek.
- After edge EL:
  - out_valid=0, busy=0.
  - If data_in_valid=1 at EL+1, the next item is accepted there.
- Latency:
  - first byte is valid one cycle after the accept edge;
  - throughput is 1 byte/cycle;
  - an item occupies L+1 cycles including the idle accept cycle.
- busy therefore rises with the first byte and falls in the cycle after the last byte. A source holds its item until the falling edge of busy, then presents the next one.
- Output is stable across the whole cycle; sampling at the falling clock edge is valid.
- out_valid is never high while reset is asserted or in the cycle after reset.

## Test plan
- **Reset:** hold reset 3 cycles → busy=0, out_valid=0, decompressed_byte=0; after release, no out_valid until an item is sent.
- **Literals:** send literals 16'h0041, 16'h0042, 16'h0043 (control 0), each waiting for busy to fall. Required:
  - out 'A','B','C', each with a single out_valid pulse one cycle after acceptance;
  - busy high exactly 1 cycle per item.
- **Non-overlapping copy:** after "ABC", send copy 16'h0003 (offset 3, L 3) → out "ABC", out_valid high for 3 consecutive cycles, busy high those 3 cycles.
- **Overlapping and maximum copy:** after literal 'x', send copy 16'hF001 (offset 1, L 18) → 18 consecutive 'x' bytes.
- **Busy protocol:** change data_in while busy=1 → the change is ignored; no extra bytes appear, and the total byte count equals the sum of L.
- **Reset mid-copy and wrap-around:**
  - Reset during a copy → output stops next cycle and the state returns to reset values.
  - With HISTORY_SIZE=256, emit more than 256 bytes, then copy at offset 256 → matches the byte emitted 256 positions earlier.
